slc3_mem_arbiter: RTL and testbench

Shares the single SLC-3 SRAM between two requesters: the CPU control path (fetch/load/store sequencing) and a debug/loader port (program upload, memory inspection). The block owns all SRAM wait-state sequencing, so requesters issue a level request and wait for a one-cycle done pulse instead of counting cycles themselves. It sits between the control unit/datapath MDR-MAR path and the SRAM pins, and generates the internal active-high Mem_OE/Mem_WE strobes plus the data-bus drive enable.

---
 rtl/slc3_mem_arbiter_pkg.sv | 25 ++
 rtl/slc3_mem_arbiter_if.sv | 46 ++++
 rtl/slc3_mem_arbiter_rr_arb2.sv | 24 ++
 rtl/slc3_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_slc3_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_mem_arbiter_pkg.sv
// Shared types and defaults for the SLC-3 SRAM arbiter and the control unit.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR,
        WR_HOLD,
        DONE
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_e;

    localparam int DEF_RD_WAIT = 2;
    localparam int DEF_WR_WAIT = 2;

    function automatic int max_wait(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slc3_mem_arbiter_if.sv
// Requester handshakes (CPU and debug) plus the SRAM pin side of the arbiter.
interface slc3_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              Mem_OE;
    logic              Mem_WE;
    logic              mem_drive;
    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_done,
        input  mem_addr, mem_wdata, Mem_OE, Mem_WE, mem_drive, busy,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_done,
        output mem_addr, mem_wdata, Mem_OE, Mem_WE, mem_drive, busy,
        input  mem_rdata
    );

endinterface

// File: rtl/slc3_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is the CPU, bit 1 the debug port.
module rr_arb2
    import slc3_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_grant,
    input  logic       enable,
    output logic       grant_valid,
    output owner_e     grant_owner
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        grant_valid = enable && (req != 2'b00);
        grant_owner = OWN_CPU;
        case (req)
            2'b01:   grant_owner = OWN_CPU;
            2'b10:   grant_owner = OWN_DBG;
            2'b11:   grant_owner = (last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
            default: grant_owner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// SRAM arbiter: grants CPU or debug port, sequences OE/WE wait states, returns a done pulse.
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = DEF_RD_WAIT,
    parameter int WR_WAIT = DEF_WR_WAIT
) (
    input logic               Clk,
    input logic               Reset,
    slc3_mem_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(max_wait(RD_WAIT, WR_WAIT) + 1);

    state_e            state;
    owner_e            owner;
    owner_e            last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              grant_valid;
    owner_e            grant_owner;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    rr_arb2 u_arb (
        .req         ({bus.dbg_req, bus.cpu_req}),
        .last_grant  (last_grant),
        .enable      (state == IDLE),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign g_we    = (grant_owner == OWN_CPU) ? bus.cpu_we    : bus.dbg_we;
    assign g_addr  = (grant_owner == OWN_CPU) ? bus.cpu_addr  : bus.dbg_addr;
    assign g_wdata = (grant_owner == OWN_CPU) ? bus.cpu_wdata : bus.dbg_wdata;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            owner         <= OWN_CPU;
            last_grant    <= OWN_DBG;
            cnt           <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_rdata <= '0;
            bus.dbg_rdata <= '0;
            bus.cpu_done  <= 1'b0;
            bus.dbg_done  <= 1'b0;
            bus.Mem_OE    <= 1'b0;
            bus.Mem_WE    <= 1'b0;
            bus.mem_drive <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make each done a single-cycle pulse.
            bus.cpu_done <= 1'b0;
            bus.dbg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner         <= grant_owner;
                        last_grant    <= grant_owner;
                        bus.mem_addr  <= g_addr;
                        bus.mem_wdata <= g_wdata;
                        bus.busy      <= 1'b1;
                        if (g_we) begin
                            cnt           <= CNT_W'(WR_WAIT);
                            bus.mem_drive <= 1'b1;
                            state         <= WR_SETUP;
                        end else begin
                            cnt        <= CNT_W'(RD_WAIT);
                            bus.Mem_OE <= 1'b1;
                            state      <= RD;
                        end
                    end
                end
                RD: begin
                    if (cnt == CNT_W'(1)) begin
                        if (owner == OWN_CPU) begin
                            bus.cpu_rdata <= bus.mem_rdata;
                            bus.cpu_done  <= 1'b1;
                        end else begin
                            bus.dbg_rdata <= bus.mem_rdata;
                            bus.dbg_done  <= 1'b1;
                        end
                        bus.Mem_OE <= 1'b0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WR_SETUP: begin
                    bus.Mem_WE <= 1'b1;
                    state      <= WR;
                end
                WR: begin
                    if (cnt == CNT_W'(1)) begin
                        bus.Mem_WE <= 1'b0;
                        state      <= WR_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    bus.mem_drive <= 1'b0;
                    bus.cpu_done  <= (owner == OWN_CPU);
                    bus.dbg_done  <= (owner == OWN_DBG);
                    state         <= DONE;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.Mem_OE    <= 1'b0;
                    bus.Mem_WE    <= 1'b0;
                    bus.mem_drive <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed bench: one arbiter at default wait states plus two with swept RD_WAIT/WR_WAIT.
module tb_slc3_mem_arbiter;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic        cpu_req [3];
    logic        cpu_we [3];
    logic [15:0] cpu_addr [3];
    logic [15:0] cpu_wdata [3];
    logic        dbg_req [3];
    logic        dbg_we [3];
    logic [15:0] dbg_addr [3];
    logic [15:0] dbg_wdata [3];
    logic [15:0] mem_rdata [3];

    wire [2:0]       mem_oe, mem_we, mem_drv, busy_o, cpu_done_o, dbg_done_o;
    wire [2:0][15:0] cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        slc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
        assign bus.cpu_req   = cpu_req[g];
        assign bus.cpu_we    = cpu_we[g];
        assign bus.cpu_addr  = cpu_addr[g];
        assign bus.cpu_wdata = cpu_wdata[g];
        assign bus.dbg_req   = dbg_req[g];
        assign bus.dbg_we    = dbg_we[g];
        assign bus.dbg_addr  = dbg_addr[g];
        assign bus.dbg_wdata = dbg_wdata[g];
        assign bus.mem_rdata = mem_rdata[g];
        assign mem_oe[g]      = bus.Mem_OE;
        assign mem_we[g]      = bus.Mem_WE;
        assign mem_drv[g]     = bus.mem_drive;
        assign busy_o[g]      = bus.busy;
        assign cpu_done_o[g]  = bus.cpu_done;
        assign dbg_done_o[g]  = bus.dbg_done;
        assign cpu_rdata_o[g] = bus.cpu_rdata;
        assign dbg_rdata_o[g] = bus.dbg_rdata;
        assign mem_addr_o[g]  = bus.mem_addr;
        assign mem_wdata_o[g] = bus.mem_wdata;

        slc3_mem_arbiter #(
            .ADDR_W  (16),
            .DATA_W  (16),
            .RD_WAIT ((g == 0) ? 2 : ((g == 1) ? 1 : 3)),
            .WR_WAIT ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) dut (
            .Clk   (Clk),
            .Reset (Reset),
            .bus   (bus)
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int rdw(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic int wrw(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int d, input bit port, input bit v, input bit we,
                           input logic [15:0] a, input logic [15:0] w);
        if (port == 1'b0) begin
            cpu_req[d] = v; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = w;
        end else begin
            dbg_req[d] = v; dbg_we[d] = we; dbg_addr[d] = a; dbg_wdata[d] = w;
        end
    endtask

    // One transaction on one port of DUT d, checking strobe widths, latency and data.
    task automatic xact(input int d, input bit port, input bit we, input logic [15:0] a,
                        input logic [15:0] w, input logic [15:0] rd, input string tag);
        int oe_cnt = 0, we_cnt = 0, we_first = 0, done_cyc = 0;
        int bad = 0, drv_bad = 0;
        int rw = rdw(d);
        int ww = wrw(d);
        @(negedge Clk);
        mem_rdata[d] = rd;
        set_req(d, port, 1'b1, we, a, w);
        for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
            @(negedge Clk);
            if (k == 1) set_req(d, port, 1'b1, ~we, ~a, ~w);
            if (mem_oe[d]) begin
                oe_cnt++;
                if (mem_addr_o[d] !== a) bad++;
            end
            if (mem_we[d]) begin
                we_cnt++;
                if (we_first == 0) we_first = k;
                if (mem_addr_o[d] !== a || mem_wdata_o[d] !== w) bad++;
            end
            if (mem_oe[d] && (mem_we[d] || mem_drv[d])) bad++;
            if (we && k <= ww + 2 && !mem_drv[d]) drv_bad++;
            if ((port == 1'b0) ? dbg_done_o[d] : cpu_done_o[d]) bad++;
            if ((port == 1'b0) ? cpu_done_o[d] : dbg_done_o[d]) done_cyc = k;
        end
        set_req(d, port, 1'b0, 1'b0, 16'h0, 16'h0);
        check({tag, "_latency"}, done_cyc, we ? ww + 3 : rw + 1);
        check({tag, "_oe_width"}, oe_cnt, we ? 0 : rw);
        check({tag, "_we_width"}, we_cnt, we ? ww : 0);
        if (we) check({tag, "_we_after_setup"}, we_first, 2);
        if (we) check({tag, "_drive"}, drv_bad, 0);
        check({tag, "_bus_errors"}, bad, 0);
        if (!we) check({tag, "_rdata"}, (port == 1'b0) ? cpu_rdata_o[d] : dbg_rdata_o[d], rd);
        @(negedge Clk);
        check({tag, "_idle_after"}, {cpu_done_o[d], dbg_done_o[d], busy_o[d]}, 3'b000);
        check({tag, "_addr_hold"}, mem_addr_o[d], a);
    endtask

    // Both ports request reads on DUT 0; expect CPU first, then strict alternation.
    task automatic both_reads(input int n, input string tag);
        int got_own [4];
        int got_cyc [4];
        int cnt = 0, both = 0;
        @(negedge Clk);
        mem_rdata[0] = 16'h0F0F;
        set_req(0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
        set_req(0, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
        for (int k = 1; k <= 60 && cnt < n; k++) begin
            @(negedge Clk);
            if (cpu_done_o[0] && dbg_done_o[0]) both++;
            if (cpu_done_o[0] || dbg_done_o[0]) begin
                got_own[cnt] = dbg_done_o[0] ? 1 : 0;
                got_cyc[cnt] = k;
                cnt++;
            end
        end
        cpu_req[0] = 1'b0;
        dbg_req[0] = 1'b0;
        check({tag, "_count"}, cnt, n);
        check({tag, "_both_done"}, both, 0);
        for (int i = 0; i < cnt; i++) begin
            check($sformatf("%s_owner%0d", tag, i), got_own[i], i % 2);
            check($sformatf("%s_cycle%0d", tag, i), got_cyc[i], 3 + 4 * i);
        end
        @(negedge Clk);
        check({tag, "_idle"}, busy_o[0], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cpu_dc, dbg_dc, dbg_addr_seen, we_seen, stray;
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            set_req(i, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            mem_rdata[i] = 16'h0;
        end
        repeat (2) @(negedge Clk);
        check("reset_strobes", {mem_oe[0], mem_we[0], mem_drv[0], busy_o[0]}, 4'b0000);
        check("reset_done", {cpu_done_o[0], dbg_done_o[0]}, 2'b00);
        check("reset_cpu_rdata", cpu_rdata_o[0], 16'h0);
        check("reset_dbg_rdata", dbg_rdata_o[0], 16'h0);
        check("reset_mem_addr", mem_addr_o[0], 16'h0);
        Reset = 1'b0;

        xact(0, 1'b0, 1'b0, 16'h3000, 16'h0, 16'hBEEF, "t1_cpu_rd");
        check("t1_dbg_rdata", dbg_rdata_o[0], 16'h0);

        xact(0, 1'b1, 1'b1, 16'h0042, 16'h1234, 16'h0, "t2_dbg_wr");
        check("t2_wdata_hold", mem_wdata_o[0], 16'h1234);

        do_reset();
        both_reads(3, "t3_rr");

        // Debug request arrives while the CPU read is in flight.
        @(negedge Clk);
        cpu_dc = 0; dbg_dc = 0; dbg_addr_seen = 0;
        mem_rdata[0] = 16'hA5A5;
        set_req(0, 1'b0, 1'b1, 1'b0, 16'h000A, 16'h0);
        for (int k = 1; k <= 30 && dbg_dc == 0; k++) begin
            @(negedge Clk);
            if (k == 1) set_req(0, 1'b1, 1'b1, 1'b0, 16'h0014, 16'h0);
            if (mem_oe[0] && cpu_dc != 0 && mem_addr_o[0] == 16'h0014) dbg_addr_seen = 1;
            if (cpu_done_o[0]) begin
                cpu_dc = k;
                cpu_req[0] = 1'b0;
                mem_rdata[0] = 16'h5A5A;
            end
            if (dbg_done_o[0]) dbg_dc = k;
        end
        dbg_req[0] = 1'b0;
        check("t4_cpu_done_cycle", cpu_dc, 3);
        check("t4_dbg_done_cycle", dbg_dc, 7);
        check("t4_dbg_addr", dbg_addr_seen, 1);
        check("t4_cpu_rdata", cpu_rdata_o[0], 16'hA5A5);
        check("t4_dbg_rdata", dbg_rdata_o[0], 16'h5A5A);

        // Reset in the second WR cycle of a debug write.
        @(negedge Clk);
        we_seen = 0; stray = 0;
        set_req(0, 1'b1, 1'b1, 1'b1, 16'h0055, 16'h0066);
        for (int k = 1; k <= 10 && we_seen < 2; k++) begin
            @(negedge Clk);
            if (mem_we[0]) we_seen++;
        end
        check("t5_we_reached", we_seen, 2);
        Reset = 1'b1;
        #1;
        check("t5_async_clear", {mem_we[0], mem_drv[0], busy_o[0], mem_oe[0]}, 4'b0000);
        dbg_req[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (k == 1) Reset = 1'b0;
            if (cpu_done_o[0] || dbg_done_o[0]) stray++;
        end
        check("t5_no_done", stray, 0);
        both_reads(1, "t5_first_grant");

        xact(1, 1'b0, 1'b0, 16'h0100, 16'h0, 16'hC001, "t6_rd1");
        xact(1, 1'b1, 1'b1, 16'h0200, 16'h7777, 16'h0, "t6_wr1");
        xact(2, 1'b1, 1'b0, 16'h0300, 16'h0, 16'hD00D, "t6_rd3");
        xact(2, 1'b0, 1'b1, 16'h0400, 16'h9999, 16'h0, "t6_wr4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
